// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache for the fetch stage.
// Hits return combinationally; misses refill a whole line, one word per beat.
module icache_direct #(
    parameter int unsigned NUM_SETS     = 32,
    parameter int unsigned LINE_WORDS   = 4,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        inv_all,
    output logic [31:0] instr,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OFF   = $clog2(LINE_WORDS);
    localparam int unsigned IDX   = $clog2(NUM_SETS);
    localparam int unsigned TAGW  = 32 - OFF - IDX - 2;
    localparam int unsigned LINEW = 32 - OFF - 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_e;

    state_e              state_q, state_d;
    logic [OFF-1:0]      beat_q, beat_d;
    logic [LINEW-1:0]    miss_q, miss_d;
    logic                inv_pend_q, inv_pend_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;

    logic [TAGW-1:0]     tag_arr  [NUM_SETS];
    logic [31:0]         data_arr [NUM_SETS][LINE_WORDS];

    logic [OFF-1:0]      pc_word;
    logic [IDX-1:0]      pc_idx;
    logic [TAGW-1:0]     pc_tag;
    logic [IDX-1:0]      miss_idx;
    logic [TAGW-1:0]     miss_tag;
    logic                hit;
    logic                refill;
    logic                last_beat;
    logic                unused_ok;

    assign pc_word  = pc[OFF+1:2];
    assign pc_idx   = pc[OFF+IDX+1:OFF+2];
    assign pc_tag   = pc[31:OFF+IDX+2];
    assign miss_idx = miss_q[IDX-1:0];
    assign miss_tag = miss_q[LINEW-1:IDX];

    // Byte offset bits and the reset vector play no part in the lookup.
    assign unused_ok = ^{pc[1:0], RESET_VECTOR};

    assign refill    = (state_q == S_REFILL);
    assign last_beat = refill && mem_valid &&
                       (beat_q == OFF'(LINE_WORDS - 1));

    assign hit = !rst && (state_q == S_IDLE) && valid_q[pc_idx] &&
                 (tag_arr[pc_idx] == pc_tag);

    assign instr    = hit ? data_arr[pc_idx][pc_word] : NOP;
    assign stall    = !rst && !hit;
    assign mem_req  = refill;
    assign mem_addr = refill ? {miss_q, {(OFF + 2){1'b0}}} : 32'h0;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        miss_d     = miss_q;
        inv_pend_d = inv_pend_q;
        valid_d    = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (inv_all) valid_d = '0;
                if (!hit) begin
                    miss_d  = {pc_tag, pc_idx};
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (inv_all) begin
                    valid_d    = '0;
                    inv_pend_d = 1'b1;
                end
                if (mem_valid) beat_d = beat_q + 1'b1;
                // An invalidate seen at any point during the refill poisons the line.
                if (last_beat) begin
                    valid_d[miss_idx] = !inv_pend_q && !inv_all;
                    inv_pend_d        = 1'b0;
                    state_d           = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            miss_q     <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            miss_q     <= miss_d;
            inv_pend_q <= inv_pend_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (refill && mem_valid) data_arr[miss_idx][beat_q] <= mem_rdata;
        if (last_beat) tag_arr[miss_idx] <= miss_tag;
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed test plan plus randomized traffic
// checked every cycle against a line-level cache model.
module tb_icache_direct;

    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        inv_all;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    icache_direct dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .inv_all   (inv_all),
        .instr     (instr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_init [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // Line-level model: per-set valid/tag/words plus one outstanding refill.
    bit          mv [32];
    logic [22:0] mt [32];
    logic [31:0] md [32][4];
    bit          m_ref;
    logic [31:0] m_line;
    int          m_cnt;
    bit          m_rinv;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'd31);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = set_of(a);
        return !m_ref && mv[s] && (mt[s] == a[31:9]);
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit h;
        int s;
        if (rst) begin
            m_ref  = 0;
            m_cnt  = 0;
            m_rinv = 0;
            foreach (mv[i]) mv[i] = 0;
        end else if (!m_ref) begin
            h = m_hit(pc);
            if (inv_all) foreach (mv[i]) mv[i] = 0;
            if (!h) begin
                m_ref  = 1;
                m_line = pc & ~32'hF;
                m_cnt  = 0;
                m_rinv = 0;
            end
        end else begin
            s = set_of(m_line);
            if (inv_all) begin
                foreach (mv[i]) mv[i] = 0;
                m_rinv = 1;
            end
            if (mem_valid) begin
                md[s][m_cnt] = mem_rdata;
                m_cnt++;
                if (m_cnt == 4) begin
                    mt[s] = m_line[31:9];
                    mv[s] = !m_rinv;
                    m_ref = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit h;
        if (rst) begin
            chk("rst_instr", instr, NOP);
            chk("rst_stall", {31'b0, stall}, 0);
            chk("rst_req", {31'b0, mem_req}, 0);
            chk("rst_addr", mem_addr, 0);
        end else begin
            h = m_hit(pc);
            chk("instr", instr, h ? md[set_of(pc)][pc[3:2]] : NOP);
            chk("stall", {31'b0, stall}, {31'b0, !h});
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_ref});
            if (m_ref) chk("mem_addr", mem_addr, m_line);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = m_ref ? mem_word(m_line + 32'(4 * m_cnt)) : $urandom;
    endtask

    task automatic wait_done(input string n);
        for (int i = 0; i < 40 && stall === 1'b1; i++) begin
            tick();
            #1;
        end
        chk(n, {31'b0, stall}, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t, s, w;
        t = $urandom_range(0, 7);
        s = $urandom_range(0, 3);
        w = $urandom_range(0, 15);
        return 32'h80000000 | (t << 9) | (s << 4) | w;
    endfunction

    initial begin
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        mem_init[RV]      = 32'h11111111;
        mem_init[RV + 4]  = 32'h22222222;
        mem_init[RV + 8]  = 32'h33333333;
        mem_init[RV + 12] = 32'h44444444;
        rst = 1; pc = RV; inv_all = 0; mem_valid = 0; mem_rdata = 0;
        repeat (3) tick();

        // cold start
        rst = 0; mem_valid = 1; #1;
        chk("t1_c0_stall", {31'b0, stall}, 1);
        chk("t1_c0_instr", instr, NOP);
        for (int c = 1; c <= 4; c++) begin
            tick(); #1;
            chk("t1_req", {31'b0, mem_req}, 1);
            chk("t1_addr", mem_addr, RV);
        end
        tick(); #1;
        chk("t1_c5_stall", {31'b0, stall}, 0);
        chk("t1_c5_instr", instr, 32'h11111111);
        chk("t1_c5_req", {31'b0, mem_req}, 0);

        // same-line hits
        tick(); pc = RV + 4; #1;
        chk("t2_hit1", instr, 32'h22222222);
        chk("t2_req1", {31'b0, mem_req | stall}, 0);
        tick(); pc = RV + 12; #1;
        chk("t2_hit2", instr, 32'h44444444);
        chk("t2_req2", {31'b0, mem_req | stall}, 0);

        // conflict eviction
        tick(); pc = RV + 32'h200; #1;
        chk("t3_miss_a", {31'b0, stall}, 1);
        tick(); #1;
        chk("t3_addr_a", mem_addr, RV + 32'h200);
        wait_done("t3_done_a");
        chk("t3_instr_a", instr, mem_word(RV + 32'h200));
        tick(); pc = RV; #1;
        chk("t3_miss_b", {31'b0, stall}, 1);
        tick(); #1;
        chk("t3_addr_b", mem_addr, RV);
        wait_done("t3_done_b");
        chk("t3_instr_b", instr, 32'h11111111);

        // wait states
        tick(); pc = RV + 32'h100; #1;
        chk("t4_miss", {31'b0, stall}, 1);
        for (int k = 0; k < 7; k++) begin
            tick(); mem_valid = pat[k][0]; #1;
            chk("t4_hold", {31'b0, stall}, 1);
        end
        tick(); mem_valid = 1; #1;
        chk("t4_hit", {31'b0, stall}, 0);
        chk("t4_w0", instr, mem_word(RV + 32'h100));
        for (int w = 1; w < 4; w++) begin
            tick(); pc = RV + 32'h100 + 32'(4 * w); #1;
            chk("t4_word", instr, mem_word(pc));
        end

        // inv_all during refill
        tick(); pc = RV + 32'h300; #1;
        chk("t5_miss", {31'b0, stall}, 1);
        tick(); tick();
        tick(); inv_all = 1;
        tick(); inv_all = 0; #1;
        chk("t5_beat3_req", {31'b0, mem_req}, 1);
        tick(); #1;
        chk("t5_remiss", {31'b0, stall}, 1);
        chk("t5_idle", {31'b0, mem_req}, 0);
        tick(); #1;
        chk("t5_req2", {31'b0, mem_req}, 1);
        chk("t5_addr2", mem_addr, RV + 32'h300);
        wait_done("t5_done");
        chk("t5_instr", instr, mem_word(RV + 32'h300));
        tick(); pc = RV; #1;
        chk("t5_old_inval", {31'b0, stall}, 1);
        wait_done("t5_done_b");
        tick(); inv_all = 1; #1;
        chk("t5_idle_inv_hit", instr, 32'h11111111);
        tick(); inv_all = 0; #1;
        chk("t5_after_inv", {31'b0, stall}, 1);
        wait_done("t5_done_c");

        // asynchronous reset mid-refill
        tick(); pc = RV + 32'h400; #1;
        chk("t6_miss", {31'b0, stall}, 1);
        tick(); tick(); tick();
        #2 rst = 1; #1;
        chk("t6_rst_req", {31'b0, mem_req}, 0);
        chk("t6_rst_stall", {31'b0, stall}, 0);
        tick(); tick(); rst = 0; #1;
        chk("t6_remiss", {31'b0, stall}, 1);
        tick(); #1;
        chk("t6_addr", mem_addr, RV + 32'h400);
        chk("t6_beat0", mem_rdata, mem_word(RV + 32'h400));
        wait_done("t6_done");
        chk("t6_w0", instr, mem_word(RV + 32'h400));
        tick(); pc = RV + 32'h408; #1;
        chk("t6_w2", instr, mem_word(RV + 32'h408));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!m_ref || $urandom_range(0, 3) == 0) pc = rand_pc();
            mem_valid = ($urandom_range(0, 3) != 0);
            inv_all   = ($urandom_range(0, 39) == 0);
        end
        inv_all = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
